conv_encoder_k: RTL
===================

Name: conv_encoder_k

Overview:
Parametrised rate-1/N, constraint-length-K convolutional encoder with valid/ready streaming on both sides.
- Optional zero-tail frame termination.
- Generalises the fixed K=4, rate-1/2 shift-register encoder feeding the Viterbi decoder path.
- Sits between the bit source and the channel/decoder model; one input bit in produces one N-bit symbol out.

Parameters:
K, 4, constraint length (>=2); state register is K-1 bits.
N, 2, code symbols per input bit (>=2).
GENS, 8'b1101_1111, packed generators; GENS[j*K +: K] is the generator for out_sym[j].
TERMINATE, 1, 1 = append K-1 zero tail bits after in_last; 0 = no tail.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  input bit valid
in_ready  out  1  encoder accepts in_bit this cycle
in_bit  in  1  data bit
in_last  in  1  marks last data bit of frame
out_valid  out  1  out_sym valid
out_ready  in  1  downstream accepts symbol
out_sym  out  N  code symbol; out_sym[j] uses generator j
out_last  out  1  final symbol of frame
state  out  K-1  encoder shift register (debug/visibility)
busy  out  1  high in FLUSH state or while out_valid is high

Behaviour:
- Reset: sampled on clk rising edge while reset==0. On that edge:
  - state=0, out_valid=0, out_sym=0, out_last=0, FSM=ENCODE.
  - Any pending symbol is dropped; mid-frame reset aborts the frame with no tail.
- Window: w = {b, state}, K bits.
  - w[K-1] = current bit b; w[K-2] = most recent past bit; w[0] = oldest.
  - Symbol: out_sym[j] = XOR-reduce(w & GENS[j*K +: K]).
  - Shift on each encoded bit: state <= {b, state[K-2:1]}.
- Output register: one stage. Symbol appears on out_valid the cycle after its bit is taken (latency 1).
  - Holds stable (out_sym, out_last) while out_valid && !out_ready.
- Accept condition: slot_free = !out_valid || out_ready.
  - A same-cycle consume and new encode is allowed, giving full throughput of 1 symbol/cycle.
- FSM states:
  - ENCODE:
    - in_ready = slot_free.
    - On in_valid && in_ready: encode b=in_bit.
    - If in_last && TERMINATE: go to FLUSH, tail_cnt=K-2, out_last=0.
    - If in_last && !TERMINATE: out_last=1 on this symbol, state <= 0 after it, stay in ENCODE.
    - Otherwise out_last=0.
  - FLUSH:
    - in_ready=0.
    - On each slot_free cycle: encode b=0.
    - When tail_cnt==0: that symbol has out_last=1, go to ENCODE (state is now 0 by construction).
    - Otherwise decrement tail_cnt.
- in_bit and in_last are ignored when !in_valid. in_ready never depends combinationally on in_valid.
- Back-to-back frames: the first bit of the next frame may be accepted in the cycle the final tail symbol is consumed.
- Frame of a single bit with TERMINATE=1 yields exactly K symbols.

Test Plan:
1. K=4, N=2, defaults; frame 1,0,0,1,1,0,1 (last on final bit), out_ready=1 → out_sym sequence 11,11,01,00,00,10,01,00,01,11; out_last only on 10th symbol; state==000 after.
2. Same frame, out_ready toggled 1/0 each cycle → identical symbol sequence; out_sym stable during stalls; in_ready low whenever out_valid && !out_ready; no symbol lost or duplicated.
3. Two back-to-back frames, second = single bit 1 → second frame yields 4 symbols 11,11,01,11 with out_last on the last; no idle cycle between frames when out_ready=1.
4. TERMINATE=0, frame 1,0,0 → symbols 11,11,01, out_last on 3rd; next frame bit 1 gives 11 (state cleared).
5. Assert reset=0 for one cycle during FLUSH after the 7-bit frame → next edge: out_valid=0, state=0, FSM=ENCODE, in_ready=1; a following frame encodes as from reset.
6. K=3, N=3, GENS={3'b111,3'b101,3'b011} (g2,g1,g0 order), input 1,1 with TERMINATE=1 → 4 symbols, out_sym[j] matching a reference model; out_last on 4th.

Source files
------------

// File: rtl/conv_encoder_k.sv
// Rate-1/N, constraint-length-K convolutional encoder with valid/ready on
// both sides. One accepted input bit produces one N-bit code symbol one cycle
// later. With TERMINATE set, a frame is closed by K-1 zero tail bits that
// return the shift register to the all-zero state.
module conv_encoder_k #(
    parameter int             K         = 4,
    parameter int             N         = 2,
    parameter logic [N*K-1:0] GENS      = 8'b1101_1111,
    parameter bit             TERMINATE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bit,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sym,
    output logic         out_last,
    output logic [K-2:0] state,
    output logic         busy
);

    // Tail counter must hold K-2; keep at least one bit for K=2.
    localparam int TW = (K > 2) ? $clog2(K - 1) : 1;

    typedef enum logic {
        ENCODE = 1'b0,
        FLUSH  = 1'b1
    } fsm_e;

    fsm_e          fsm_q;
    fsm_e          fsm_d;
    logic [TW-1:0] tail_cnt;
    logic [TW-1:0] tail_d;

    logic          slot_free;
    logic          enc_go;     // a bit (data or tail) is encoded this cycle
    logic          enc_bit;    // the bit being encoded
    logic          enc_last;   // the produced symbol closes the frame
    logic          enc_clear;  // unterminated frame end: restart from zero
    logic [K-1:0]  window;
    logic [N-1:0]  sym_d;

    // The output register can take a new symbol when empty or being drained.
    assign slot_free = !out_valid || out_ready;

    // Current bit on top, oldest past bit at index 0.
    assign window = {enc_bit, state};

    // Next-state logic: decide whether and what to encode, and FSM progress.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        fsm_d     = fsm_q;
        tail_d    = tail_cnt;
        enc_go    = 1'b0;
        enc_bit   = 1'b0;
        enc_last  = 1'b0;
        enc_clear = 1'b0;
        case (fsm_q)
            ENCODE: begin
                if (in_valid && slot_free) begin
                    enc_go  = 1'b1;
                    enc_bit = in_bit;
                    if (in_last) begin
                        if (TERMINATE) begin
                            fsm_d  = FLUSH;
                            tail_d = TW'(K - 2);
                        end else begin
                            enc_last  = 1'b1;
                            enc_clear = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    enc_go  = 1'b1;
                    enc_bit = 1'b0;
                    if (tail_cnt == '0) begin
                        enc_last = 1'b1;
                        fsm_d    = ENCODE;
                    end else begin
                        tail_d = tail_cnt - TW'(1);
                    end
                end
            end
            default: fsm_d = ENCODE;
        endcase
    end

    // Symbol generation: each output bit is the parity of the window taps.
    always_comb begin
        sym_d = '0;
        for (int j = 0; j < N; j++) begin
            sym_d[j] = ^(window & GENS[j*K +: K]);
        end
    end

    // Output logic: input handshake and activity flag from registered state.
    always_comb begin
        in_ready = 1'b0;
        if (fsm_q == ENCODE) begin
            in_ready = slot_free;
        end
        busy = (fsm_q == FLUSH) || out_valid;
    end

    // State register: FSM, shift register and the one-deep output stage.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (!reset) begin
            fsm_q     <= ENCODE;
            tail_cnt  <= '0;
            state     <= '0;
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_last  <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            tail_cnt <= tail_d;
            if (enc_go) begin
                state     <= enc_clear ? '0 : window[K-1:1];
                out_sym   <= sym_d;
                out_last  <= enc_last;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
